// File: rtl/wb_stream_writer_seq.sv
// wb_stream_writer_seq
//   Queues stream-writer descriptors and plays each one out as a sequence of
//   Wishbone classic single writes to the stream writer's config slave:
//   0x4=start, 0x8=size, 0xC=burst, 0x0=1 (enable), then waits for the
//   completion interrupt and writes 0x0=2 (clear).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   desc_*_i, desc_valid_i descriptor fields and push strobe
//   desc_ready_o          descriptor queue not full
//   wbm_*_o / wbm_*_i     Wishbone master towards the config slave
//   stream_irq_i          completion interrupt (level)
//   done_o / err_o        one-cycle pulse per descriptor completed / aborted
//   busy_o                sequencer not idle
module wb_stream_writer_seq #(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int DESC_AW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WB_AW-1:0]   desc_start_addr_i,
    input  logic [WB_DW-1:0]   desc_buf_size_i,
    input  logic [WB_DW-1:0]   desc_burst_len_i,
    input  logic               desc_valid_i,
    output logic               desc_ready_o,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic               stream_irq_i,
    output logic               done_o,
    output logic               err_o,
    output logic               busy_o
);

    localparam int unsigned      DEPTH   = 1 << DESC_AW;
    localparam logic [DESC_AW:0] FULL_CT = {1'b1, {DESC_AW{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_SIZE, WR_BURST, WR_EN, WAIT_IRQ, WR_CLR, FINISH
    } state_t;

    state_t state_q, state_d;

    // Descriptor queue
    logic [WB_AW-1:0]   q_addr  [DEPTH];
    logic [WB_DW-1:0]   q_size  [DEPTH];
    logic [WB_DW-1:0]   q_burst [DEPTH];
    logic [DESC_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [DESC_AW:0]   count_q, count_d;
    logic               full, empty, push, pop;

    // Working copy of the descriptor being executed
    logic [WB_AW-1:0] cur_addr_q;
    logic [WB_DW-1:0] cur_size_q, cur_burst_q;

    logic cyc_q, cyc_d;
    logic err_q, err_d;

    logic             is_wr;
    state_t           wr_next;
    logic [WB_AW-1:0] wr_adr;
    logic [WB_DW-1:0] wr_dat;

    assign full  = (count_q == FULL_CT);
    assign empty = (count_q == '0);
    assign pop   = (state_q == IDLE) && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push  = desc_valid_i && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr_q]  <= desc_start_addr_i;
            q_size[wr_ptr_q]  <= desc_buf_size_i;
            q_burst[wr_ptr_q] <= desc_burst_len_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cur_addr_q  <= '0;
            cur_size_q  <= '0;
            cur_burst_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                cur_addr_q  <= q_addr[rd_ptr_q];
                cur_size_q  <= q_size[rd_ptr_q];
                cur_burst_q <= q_burst[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        err_d   = 1'b0;
        is_wr   = 1'b0;
        wr_next = IDLE;
        wr_adr  = '0;
        wr_dat  = '0;
        unique case (state_q)
            IDLE:     if (!empty) state_d = WR_ADDR;
            WR_ADDR:  begin is_wr = 1'b1; wr_next = WR_SIZE;  wr_adr = WB_AW'(4);  wr_dat = WB_DW'(cur_addr_q); end
            WR_SIZE:  begin is_wr = 1'b1; wr_next = WR_BURST; wr_adr = WB_AW'(8);  wr_dat = cur_size_q;         end
            WR_BURST: begin is_wr = 1'b1; wr_next = WR_EN;    wr_adr = WB_AW'(12); wr_dat = cur_burst_q;        end
            WR_EN:    begin is_wr = 1'b1; wr_next = WAIT_IRQ; wr_adr = '0;         wr_dat = WB_DW'(1);          end
            WAIT_IRQ: if (stream_irq_i) state_d = WR_CLR;
            WR_CLR:   begin is_wr = 1'b1; wr_next = FINISH;   wr_adr = '0;         wr_dat = WB_DW'(2);          end
            FINISH:   state_d = IDLE;
        endcase
        // Each write state: idle one cycle, then hold cyc/stb until ack/err.
        if (is_wr) begin
            if (!cyc_q) begin
                cyc_d = 1'b1;
            end else if (wbm_err_i) begin
                cyc_d   = 1'b0;
                err_d   = 1'b1;
                state_d = IDLE;
            end else if (wbm_ack_i) begin
                cyc_d   = 1'b0;
                state_d = wr_next;
            end
        end
    end

    assign wbm_cyc_o    = cyc_q;
    assign wbm_stb_o    = cyc_q;
    assign wbm_we_o     = cyc_q;
    assign wbm_sel_o    = cyc_q ? '1 : '0;
    assign wbm_adr_o    = cyc_q ? wr_adr : '0;
    assign wbm_dat_o    = cyc_q ? wr_dat : '0;
    assign wbm_cti_o    = 3'b000;
    assign wbm_bte_o    = 2'b00;
    assign desc_ready_o = !full;
    assign done_o       = (state_q == FINISH);
    assign err_o        = err_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_wb_stream_writer_seq.sv
module tb_wb_stream_writer_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] desc_start_addr_i = '0, desc_buf_size_i = '0, desc_burst_len_i = '0;
    logic        desc_valid_i = 1'b0;
    logic        desc_ready_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
    logic        stream_irq_i = 1'b0;
    logic        done_o, err_o, busy_o;

    always #5 clk = ~clk;

    wb_stream_writer_seq #(.WB_AW(32), .WB_DW(32), .DESC_AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_start_addr_i(desc_start_addr_i), .desc_buf_size_i(desc_buf_size_i),
        .desc_burst_len_i(desc_burst_len_i), .desc_valid_i(desc_valid_i),
        .desc_ready_o(desc_ready_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .stream_irq_i(stream_irq_i),
        .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
    );

    int checks = 0;
    int failures = 0;

    // Slave-side record of acknowledged writes (written only by the slave)
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    int          proto_bad = 0;
    int          err_done = 0;
    // Test-side requests
    int          err_req = 0;
    logic [31:0] err_adr = 32'h8;
    // Expected writes (written only by the test sequence)
    logic [31:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    // Pulse counters (written only by the monitor)
    int          done_cnt = 0;
    int          err_cnt = 0;

    // Wishbone slave: ack after 0..5 wait cycles, optional one-shot err
    initial begin : slave
        int wcnt;
        int txn;
        int delay;
        wcnt = 0; txn = 0; delay = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wcnt = 0;
            end else if (wbm_ack_i || wbm_err_i) begin
                wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
            end else if (wbm_cyc_o && wbm_stb_o) begin
                if (wcnt >= delay) begin
                    wcnt = 0;
                    txn++;
                    delay = txn % 6;
                    if (err_req > err_done && wbm_adr_o == err_adr) begin
                        wbm_err_i = 1'b1;
                        err_done++;
                    end else begin
                        wbm_ack_i = 1'b1;
                        log_adr.push_back(wbm_adr_o);
                        log_dat.push_back(wbm_dat_o);
                        if (wbm_we_o !== 1'b1 || wbm_sel_o !== 4'hF ||
                            wbm_cti_o !== 3'b000 || wbm_bte_o !== 2'b00)
                            proto_bad++;
                    end
                end else begin
                    wcnt++;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(posedge clk);
            if (done_o === 1'b1) done_cnt++;
            if (err_o === 1'b1) err_cnt++;
        end
    end

    function automatic void add_exp(input logic [31:0] a, input logic [31:0] s, input logic [31:0] b);
        exp_adr.push_back(32'h4); exp_dat.push_back(a);
        exp_adr.push_back(32'h8); exp_dat.push_back(s);
        exp_adr.push_back(32'hC); exp_dat.push_back(b);
        exp_adr.push_back(32'h0); exp_dat.push_back(32'h1);
        exp_adr.push_back(32'h0); exp_dat.push_back(32'h2);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] s, input logic [31:0] b);
        desc_start_addr_i = a; desc_buf_size_i = s; desc_burst_len_i = b;
        desc_valid_i = 1'b1;
        @(posedge clk); #1;
        desc_valid_i = 1'b0;
    endtask

    task automatic wait_log(input int n, input string nm);
        int k = 0;
        while (log_adr.size() < n && k < 400) begin tick(1); k++; end
        if (log_adr.size() < n) begin
            checks++; failures++;
            $display("FAIL %s_wait_writes got=%0d want=%0d", nm, log_adr.size(), n);
        end
    endtask

    task automatic wait_done(input int n, input string nm);
        int k = 0;
        while (done_cnt < n && k < 600) begin tick(1); k++; end
        if (done_cnt < n) begin
            checks++; failures++;
            $display("FAIL %s_wait_done got=%0d want=%0d", nm, done_cnt, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, done_o, err_o, busy_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {wbm_cyc_o, wbm_stb_o, wbm_we_o, done_o, err_o, busy_o});
        end
        checks++;
        if (wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || wbm_sel_o !== 4'h0) begin
            failures++;
            $display("FAIL reset_bus adr=%h dat=%h sel=%h want 0", wbm_adr_o, wbm_dat_o, wbm_sel_o);
        end
        checks++;
        if (desc_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b want=1", desc_ready_o);
        end
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (busy_o !== 1'b0 || wbm_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle busy=%b cyc=%b want 0 0", busy_o, wbm_cyc_o);
        end
    endtask

    task automatic test_single();
        int lb = log_adr.size();
        int d0 = done_cnt;
        exp_adr.delete(); exp_dat.delete();
        add_exp(32'h40, 32'd32, 32'd4);
        stream_irq_i = 1'b0;
        push(32'h40, 32'd32, 32'd4);
        wait_log(lb + 4, "single");
        tick(10);
        checks++;
        if (log_adr.size() != lb + 4 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL single_wait_irq writes=%0d busy=%b want=%0d 1", log_adr.size() - lb, busy_o, 4);
        end
        stream_irq_i = 1'b1;
        wait_done(d0 + 1, "single");
        stream_irq_i = 1'b0;
        tick(5);
        checks++;
        if (log_adr.size() != lb + exp_adr.size()) begin
            failures++;
            $display("FAIL single_count got=%0d want=%0d", log_adr.size() - lb, exp_adr.size());
        end
        for (int i = 0; i < exp_adr.size() && lb + i < log_adr.size(); i++) begin
            checks++;
            if (log_adr[lb+i] !== exp_adr[i] || log_dat[lb+i] !== exp_dat[i]) begin
                failures++;
                $display("FAIL single_wr%0d got=%h:%h want=%h:%h", i, log_adr[lb+i], log_dat[lb+i], exp_adr[i], exp_dat[i]);
            end
        end
        checks++;
        if (done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL single_done got=%0d want=%0d", done_cnt - d0, 1);
        end
    endtask

    task automatic test_back_to_back();
        int lb = log_adr.size();
        int d0 = done_cnt;
        exp_adr.delete(); exp_dat.delete();
        for (int i = 0; i < 5; i++) add_exp(32'h1000 + i*32'h100, 32'd16 + i, 32'd1 + i);
        stream_irq_i = 1'b0;
        push(32'h1000, 32'd16, 32'd1);
        wait_log(lb + 4, "b2b");
        push(32'h1100, 32'd17, 32'd2);
        push(32'h1200, 32'd18, 32'd3);
        push(32'h1300, 32'd19, 32'd4);
        checks++;
        if (desc_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_3 got=%b want=1", desc_ready_o);
        end
        push(32'h1400, 32'd20, 32'd5);
        checks++;
        if (desc_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_full got=%b want=0", desc_ready_o);
        end
        push(32'hDEAD, 32'd99, 32'd99);
        checks++;
        if (desc_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_after_drop got=%b want=0", desc_ready_o);
        end
        stream_irq_i = 1'b1;
        wait_done(d0 + 5, "b2b");
        tick(20);
        stream_irq_i = 1'b0;
        checks++;
        if (done_cnt != d0 + 5) begin
            failures++;
            $display("FAIL b2b_done got=%0d want=%0d", done_cnt - d0, 5);
        end
        checks++;
        if (log_adr.size() != lb + exp_adr.size()) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=%0d", log_adr.size() - lb, exp_adr.size());
        end
        for (int i = 0; i < exp_adr.size() && lb + i < log_adr.size(); i++) begin
            checks++;
            if (log_adr[lb+i] !== exp_adr[i] || log_dat[lb+i] !== exp_dat[i]) begin
                failures++;
                $display("FAIL b2b_wr%0d got=%h:%h want=%h:%h", i, log_adr[lb+i], log_dat[lb+i], exp_adr[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_error();
        int lb = log_adr.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        exp_adr.delete(); exp_dat.delete();
        exp_adr.push_back(32'h4); exp_dat.push_back(32'h100);
        add_exp(32'h200, 32'd128, 32'd2);
        stream_irq_i = 1'b0;
        err_adr = 32'h8;
        err_req++;
        push(32'h100, 32'd64, 32'd8);
        push(32'h200, 32'd128, 32'd2);
        wait_log(lb + 5, "err");
        checks++;
        if (err_cnt != e0 + 1) begin
            failures++;
            $display("FAIL err_pulse got=%0d want=%0d", err_cnt - e0, 1);
        end
        stream_irq_i = 1'b1;
        wait_done(d0 + 1, "err");
        stream_irq_i = 1'b0;
        tick(10);
        checks++;
        if (done_cnt != d0 + 1 || err_cnt != e0 + 1) begin
            failures++;
            $display("FAIL err_counts done=%0d err=%0d want=1 1", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (log_adr.size() != lb + exp_adr.size()) begin
            failures++;
            $display("FAIL err_count got=%0d want=%0d", log_adr.size() - lb, exp_adr.size());
        end
        for (int i = 0; i < exp_adr.size() && lb + i < log_adr.size(); i++) begin
            checks++;
            if (log_adr[lb+i] !== exp_adr[i] || log_dat[lb+i] !== exp_dat[i]) begin
                failures++;
                $display("FAIL err_wr%0d got=%h:%h want=%h:%h", i, log_adr[lb+i], log_dat[lb+i], exp_adr[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_full_push_pop();
        int lb = log_adr.size();
        int d0 = done_cnt;
        int k = 0;
        exp_adr.delete(); exp_dat.delete();
        for (int i = 0; i < 6; i++) add_exp(32'h2000 + i*32'h10, 32'd40 + i, 32'd8 + i);
        stream_irq_i = 1'b0;
        push(32'h2000, 32'd40, 32'd8);
        wait_log(lb + 4, "fpp");
        for (int i = 1; i < 5; i++) push(32'h2000 + i*32'h10, 32'd40 + i, 32'd8 + i);
        // Hold the sixth descriptor on the port until the sequencer pops.
        desc_start_addr_i = 32'h2050; desc_buf_size_i = 32'd45; desc_burst_len_i = 32'd13;
        desc_valid_i = 1'b1;
        stream_irq_i = 1'b1;
        tick(1);
        while (busy_o && k < 300) begin tick(1); k++; end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL fpp_idle_timeout busy=%b want=0", busy_o);
        end
        tick(1);
        desc_valid_i = 1'b0;
        checks++;
        if (desc_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL fpp_still_full got=%b want=0", desc_ready_o);
        end
        wait_done(d0 + 6, "fpp");
        tick(20);
        stream_irq_i = 1'b0;
        checks++;
        if (done_cnt != d0 + 6) begin
            failures++;
            $display("FAIL fpp_done got=%0d want=%0d", done_cnt - d0, 6);
        end
        checks++;
        if (log_adr.size() != lb + exp_adr.size()) begin
            failures++;
            $display("FAIL fpp_count got=%0d want=%0d", log_adr.size() - lb, exp_adr.size());
        end
        for (int i = 0; i < exp_adr.size() && lb + i < log_adr.size(); i++) begin
            checks++;
            if (log_adr[lb+i] !== exp_adr[i] || log_dat[lb+i] !== exp_dat[i]) begin
                failures++;
                $display("FAIL fpp_wr%0d got=%h:%h want=%h:%h", i, log_adr[lb+i], log_dat[lb+i], exp_adr[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_irq_early();
        int lb = log_adr.size();
        int d0 = done_cnt;
        exp_adr.delete(); exp_dat.delete();
        add_exp(32'h3000, 32'd7, 32'd3);
        stream_irq_i = 1'b1;
        push(32'h3000, 32'd7, 32'd3);
        wait_done(d0 + 1, "early");
        tick(20);
        stream_irq_i = 1'b0;
        checks++;
        if (done_cnt != d0 + 1) begin
            failures++;
            $display("FAIL early_done got=%0d want=%0d", done_cnt - d0, 1);
        end
        checks++;
        if (log_adr.size() != lb + exp_adr.size()) begin
            failures++;
            $display("FAIL early_count got=%0d want=%0d", log_adr.size() - lb, exp_adr.size());
        end
        for (int i = 0; i < exp_adr.size() && lb + i < log_adr.size(); i++) begin
            checks++;
            if (log_adr[lb+i] !== exp_adr[i] || log_dat[lb+i] !== exp_dat[i]) begin
                failures++;
                $display("FAIL early_wr%0d got=%h:%h want=%h:%h", i, log_adr[lb+i], log_dat[lb+i], exp_adr[i], exp_dat[i]);
            end
        end
        checks++;
        if (proto_bad != 0) begin
            failures++;
            $display("FAIL bus_attrs bad_writes=%0d want=0", proto_bad);
        end
    endtask

    task automatic test_reset_mid();
        int lb = log_adr.size();
        int d0 = done_cnt;
        stream_irq_i = 1'b0;
        push(32'h4000, 32'd1, 32'd1);
        wait_log(lb + 4, "rst");
        push(32'h4100, 32'd2, 32'd2);
        push(32'h4200, 32'd3, 32'd3);
        tick(3);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_busy got=%b want=1", busy_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, done_o, err_o, busy_o} !== 6'b0 ||
            wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || wbm_sel_o !== 4'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs ctrl=%b adr=%h dat=%h sel=%h want all 0",
                     {wbm_cyc_o, wbm_stb_o, wbm_we_o, done_o, err_o, busy_o}, wbm_adr_o, wbm_dat_o, wbm_sel_o);
        end
        checks++;
        if (desc_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_ready got=%b want=1", desc_ready_o);
        end
        tick(2);
        rst_n = 1'b1;
        stream_irq_i = 1'b1;
        tick(40);
        stream_irq_i = 1'b0;
        checks++;
        if (log_adr.size() != lb + 4 || done_cnt != d0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_activity writes=%0d done=%0d busy=%b want=4 0 0",
                     log_adr.size() - lb, done_cnt - d0, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_error();
        test_full_push_pop();
        test_irq_early();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
